// File: rtl/rv32_mem_stage_pkg.sv
// Shared pipeline types for the RV32 memory stage: memory op codes, the
// exec->mem and mem->writeback buffer structs, and small helper functions.
package rv32_mem_stage_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LH       = 4'd2,
        LW       = 4'd3,
        LBU      = 4'd4,
        LHU      = 4'd5,
        SB       = 4'd6,
        SH       = 4'd7,
        SW       = 4'd8
    } mem_op_t;

    typedef struct packed {
        mem_op_t     mem_op;
        logic [4:0]  rd;
        logic        wb_en;
    } decoded_instr_t;

    typedef struct packed {
        logic [31:0]    instr;
        logic [31:0]    pc;
        decoded_instr_t decoded_instr;
        logic [31:0]    mem_addr;
        logic [31:0]    wb_result;
        logic [31:0]    store_data;
    } exec_buffer_data_t;

    typedef struct packed {
        logic           valid;
        logic [31:0]    instr;
        logic [31:0]    pc;
        decoded_instr_t decoded_instr;
        logic [31:0]    wb_result;
        logic           mem_fault;
    } mem_buffer_data_t;

    function automatic logic isStore(mem_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic isMemOp(mem_op_t op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) ||
               (op == LHU) || isStore(op);
    endfunction

    function automatic mem_buffer_data_t makeMemData(exec_buffer_data_t e,
                                                     logic [31:0] wb,
                                                     logic fault);
        mem_buffer_data_t m;
        m.valid         = 1'b1;
        m.instr         = e.instr;
        m.pc            = e.pc;
        m.decoded_instr = e.decoded_instr;
        m.wb_result     = wb;
        m.mem_fault     = fault;
        return m;
    endfunction

endpackage

// File: rtl/rv32_mem_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and
// the data memory or bus fabric (slave).
interface rv32_mem_stage_if;

    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req_valid,
        output dmem_addr,
        output dmem_we,
        output dmem_be,
        output dmem_wdata,
        input  dmem_req_ready,
        input  dmem_resp_valid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req_valid,
        input  dmem_addr,
        input  dmem_we,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_req_ready,
        output dmem_resp_valid,
        output dmem_rdata
    );

endinterface

// File: rtl/rv32_mem_align.sv
// Combinational lane logic: load byte/half extraction with sign/zero
// extension, store byte-enable and data replication, alignment checking.
module rv32_mem_align
    import rv32_mem_stage_pkg::*;
(
    input  mem_op_t     mem_op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        we_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    assign byteSel = 8'(rdata_i >> {addr_lo_i, 3'b000});
    assign halfSel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Loads always fetch the full word; the lane is picked out of rdata.
    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = 32'h0;
        we_o         = 1'b0;
        load_data_o  = 32'h0;
        misaligned_o = 1'b0;
        unique case (mem_op_i)
            LB:  load_data_o = {{24{byteSel[7]}}, byteSel};
            LBU: load_data_o = {24'h0, byteSel};
            LH: begin
                load_data_o  = {{16{halfSel[15]}}, halfSel};
                misaligned_o = addr_lo_i[0];
            end
            LHU: begin
                load_data_o  = {16'h0, halfSel};
                misaligned_o = addr_lo_i[0];
            end
            LW: begin
                load_data_o  = rdata_i;
                misaligned_o = |addr_lo_i;
            end
            SB: begin
                we_o    = 1'b1;
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            SH: begin
                we_o         = 1'b1;
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{store_data_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            SW: begin
                we_o         = 1'b1;
                wdata_o      = store_data_i;
                misaligned_o = |addr_lo_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32_mem_stage.sv
// RV32 memory stage: issues one data-memory access per instruction, stalls
// upstream until the response or a bus timeout, and registers the result.
module rv32_mem_stage
    import rv32_mem_stage_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
)
(
    input  logic              clk,
    input  logic              resetn,
    input  exec_buffer_data_t exec_data,
    output mem_buffer_data_t  mem_data,
    output logic              stall,
    rv32_mem_stage_if.master  dmem
);

    localparam int unsigned CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    timeoutCnt_q, timeoutCnt_d;
    mem_buffer_data_t memData_q, memData_d;

    mem_op_t     memOp;
    logic [3:0]  alignBe;
    logic [31:0] alignWdata;
    logic        alignWe;
    logic [31:0] loadData;
    logic        misaligned;
    logic        reqValid;
    logic        stallRaw;

    assign memOp = exec_data.decoded_instr.mem_op;

    rv32_mem_align u_align (
        .mem_op_i     (memOp),
        .addr_lo_i    (exec_data.mem_addr[1:0]),
        .store_data_i (exec_data.store_data),
        .rdata_i      (dmem.dmem_rdata),
        .be_o         (alignBe),
        .wdata_o      (alignWdata),
        .we_o         (alignWe),
        .load_data_o  (loadData),
        .misaligned_o (misaligned)
    );

    // Request fields come straight from exec_data, which upstream holds
    // stable while stall is high, so REQ needs no separate request latch.
    always_comb begin
        state_d      = state_q;
        timeoutCnt_d = timeoutCnt_q;
        memData_d    = '0;
        reqValid     = 1'b0;
        stallRaw     = 1'b0;
        unique case (state_q)
            IDLE: begin
                timeoutCnt_d = '0;
                if (!isMemOp(memOp)) begin
                    memData_d = makeMemData(exec_data, exec_data.wb_result, 1'b0);
                end else if (misaligned) begin
                    memData_d = makeMemData(exec_data, 32'h0, 1'b1);
                end else begin
                    reqValid = 1'b1;
                    stallRaw = 1'b1;
                    state_d  = dmem.dmem_req_ready ? RESP : REQ;
                end
            end
            REQ: begin
                reqValid     = 1'b1;
                stallRaw     = 1'b1;
                timeoutCnt_d = '0;
                if (dmem.dmem_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (dmem.dmem_resp_valid) begin
                    memData_d    = makeMemData(exec_data,
                                               isStore(memOp) ? 32'h0 : loadData,
                                               1'b0);
                    state_d      = IDLE;
                    timeoutCnt_d = '0;
                end else if (timeoutCnt_q == CW'(BUS_TIMEOUT - 1)) begin
                    memData_d    = makeMemData(exec_data, 32'h0, 1'b1);
                    state_d      = IDLE;
                    timeoutCnt_d = '0;
                end else begin
                    stallRaw     = 1'b1;
                    timeoutCnt_d = timeoutCnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            timeoutCnt_q <= '0;
            memData_q    <= '0;
        end else begin
            state_q      <= state_d;
            timeoutCnt_q <= timeoutCnt_d;
            memData_q    <= memData_d;
        end
    end

    // Gating with resetn keeps the handshake quiet while reset is asserted,
    // even if exec_data still carries a memory op.
    assign stall               = resetn & stallRaw;
    assign dmem.dmem_req_valid = resetn & reqValid;
    assign dmem.dmem_addr      = {exec_data.mem_addr[31:2], 2'b00};
    assign dmem.dmem_we        = alignWe;
    assign dmem.dmem_be        = alignBe;
    assign dmem.dmem_wdata     = alignWdata;
    assign mem_data            = memData_q;

endmodule

// File: doc/rv32_mem_stage.md
RV32_MEM_STAGE -- requirements
Module: rv32_mem_stage

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 255: cycles spent in RESP without dmem_resp_valid before a fault is raised.
REQ-002 SHALL have port clk  in  1  sole clock; all state on posedge clk.
REQ-003 SHALL have port resetn  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port exec_data  in  exec_buffer_data_t  registered output of the exec stage; uses instr, pc, decoded_instr, mem_addr, wb_result, store_data.
REQ-005 SHALL have port mem_data  out  mem_buffer_data_t  registered output to writeback; fields valid, instr, pc, decoded_instr, wb_result, mem_fault.
REQ-006 SHALL have port stall  out  1  upstream holds exec_data stable while high.
REQ-007 SHALL have port dmem_req_valid  out  1  request valid.
REQ-008 SHALL have port dmem_req_ready  in  1  request accepted when valid and ready are both high.
REQ-009 SHALL have ports dmem_addr (32, word-aligned), dmem_we (1), dmem_be (4) and dmem_wdata (32), all outputs.
REQ-010 SHALL have port dmem_resp_valid  in  1  one-cycle response or store acknowledge.
REQ-011 SHALL have port dmem_rdata  in  32  load data word.

Function
REQ-012 SHALL implement FSM IDLE, REQ, RESP; the encoding is local to the block.
REQ-013 In IDLE with decoded_instr.mem_op == MEM_NONE, SHALL register exec_data into mem_data next cycle: valid=1, wb_result passed through, mem_fault=0, stall=0.
REQ-014 In IDLE with an aligned memory op, SHALL assert dmem_req_valid and stall in the same cycle; on ready go to RESP, otherwise go to REQ.
REQ-015 In REQ, SHALL hold dmem_req_valid and the request fields constant until dmem_req_ready, then go to RESP; stall stays high.
REQ-016 In RESP, on dmem_resp_valid SHALL write mem_data with valid=1, drop stall combinationally in the same cycle, and return to IDLE.
REQ-017 While stall=1 and no response has completed, SHALL drive mem_data.valid=0 (bubble).
REQ-018 SHALL treat a response as valid no earlier than the cycle after request acceptance, and SHALL ignore dmem_resp_valid in IDLE or REQ.
REQ-019 Misalignment (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL issue no request and SHALL produce valid=1, mem_fault=1, wb_result=0 after 1 cycle.
REQ-020 SHALL count cycles in RESP; at BUS_TIMEOUT with no response, SHALL produce valid=1, mem_fault=1, wb_result=0 and return to IDLE.
REQ-021 Loads: byte lane = addr[1:0], half lane = addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes dmem_rdata through.
REQ-022 Stores: SB be=0001<<addr[1:0], wdata = byte replicated x4; SH be=0011<<(2*addr[1]), half replicated x2; SW be=1111. Loads drive we=0, be=1111.
REQ-023 dmem_addr SHALL equal {mem_addr[31:2],2'b00}.
REQ-024 For a store, mem_data.wb_result SHALL be 0 on acknowledge.

Reset
REQ-025 On resetn low, SHALL asynchronously set state=IDLE, timeout counter=0, mem_data all-zero (valid=0), dmem_req_valid=0 and stall=0.
REQ-026 Reset mid-transaction SHALL abandon the access; a late dmem_resp_valid after reset SHALL be ignored.

Structure
REQ-027 mem_op_t (MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH, SW), mem_buffer_data_t and the store_data field of exec_buffer_data_t SHALL live in the shared pipeline package.
REQ-028 Load extraction/extension and store lane/byte-enable generation SHALL be one combinational sub-module, rv32_mem_align.

Verification
REQ-029 ALU op, wb_result=0x1234 -> mem_data.valid=1, wb_result=0x1234 next cycle; stall never high.
REQ-030 LB at 0x1003, ready=1, response 2 cycles later with rdata=0x80FF_FFFF -> be=1111, addr=0x1000, wb_result=0xFFFF_FF80, stall high for 3 cycles.
REQ-031 SH at 0x2002, store_data=0xABCD, ready held low for 3 cycles -> request fields stable; be=1100, wdata=0xABCD_ABCD, we=1; ack yields wb_result=0.
REQ-032 LW at 0x3001 -> no dmem_req_valid; next cycle mem_fault=1, valid=1.
REQ-033 With BUS_TIMEOUT=4, LW accepted and no response -> mem_fault=1 after 4 RESP cycles; a later dmem_resp_valid is ignored.
REQ-034 resetn pulsed low while in RESP -> outputs zero immediately; a stale response after reset produces no valid output.
